compressed_bit_packer: RTL and testbench

- Sits directly downstream of the length packing pipeline register.
- Consumes one variable-length compressed word per accepted cycle (i_word carrying i_total_length valid bits).
- Concatenates the words MSB-first into OUT_WIDTH-bit output beats.
- On end of block, flushes the residual partial beat with padding and marks it last, with a valid-bit count.

---
 rtl/compressed_bit_packer.sv | 178 +++++++++++++++++
 tb/tb_compressed_bit_packer.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/compressed_bit_packer.sv
// Packs MSB-aligned variable-length words into OUT_WIDTH-bit beats, flushing a padded last beat.
// Build option: define PACKER_PAD_ONES_EN to pad the final beat with ones instead of zeros.
module compressed_bit_packer #(
    parameter int unsigned IN_WIDTH  = 64,
    parameter int unsigned LEN_WIDTH = 7,
    parameter int unsigned OUT_WIDTH = 128
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [IN_WIDTH-1:0]  i_word,
    input  logic [LEN_WIDTH-1:0] i_total_length,
    input  logic                 i_finish_final,
    output logic                 o_valid,
    input  logic                 i_out_ready,
    output logic [OUT_WIDTH-1:0] o_data,
    output logic                 o_last,
    output logic [7:0]           o_bit_count,
    output logic [7:0]           o_fill_level
);

    localparam int unsigned ACC_W  = OUT_WIDTH + IN_WIDTH;
    localparam int unsigned FILL_W = $clog2(ACC_W + 1);

    localparam logic [FILL_W-1:0]    OutWidthF = FILL_W'(OUT_WIDTH);
    localparam logic [LEN_WIDTH-1:0] InWidthL  = LEN_WIDTH'(IN_WIDTH);

`ifdef PACKER_PAD_ONES_EN
    localparam bit PadOnes = 1'b1;
`else
    localparam bit PadOnes = 1'b0;
`endif

    if (OUT_WIDTH < 2 * IN_WIDTH) begin : gen_bad_out_width
        $error("OUT_WIDTH must be at least 2*IN_WIDTH");
    end
    if ((1 << LEN_WIDTH) <= IN_WIDTH) begin : gen_bad_len_width
        $error("LEN_WIDTH too narrow to hold IN_WIDTH");
    end

    typedef enum logic [1:0] {
        StRun,
        StFlush,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [FILL_W-1:0]    fill_q, fill_d;
    logic                 pending_q, pending_d;
    logic                 valid_q, valid_d;
    logic [OUT_WIDTH-1:0] data_q, data_d;
    logic                 last_q, last_d;
    logic [7:0]           count_q, count_d;

    logic                 accept;
    logic                 beat_release;
    logic [FILL_W-1:0]    len;
    logic [FILL_W-1:0]    fill_new;
    logic [IN_WIDTH-1:0]  word_mask;
    logic [ACC_W-1:0]     acc_new;

    // Bits below the valid count become padding.
    function automatic logic [OUT_WIDTH-1:0] pad_beat(input logic [OUT_WIDTH-1:0] top,
                                                      input logic [FILL_W-1:0]    bits);
        logic [OUT_WIDTH-1:0] pad_mask;
        pad_mask = {OUT_WIDTH{1'b1}} >> bits;
        return PadOnes ? (top | pad_mask) : (top & ~pad_mask);
    endfunction

    assign o_ready      = !i_reset && (state_q == StRun) && (!valid_q || i_out_ready);
    assign accept       = i_valid && o_ready;
    assign beat_release = valid_q && i_out_ready;

    // Residual occupies the top fill_q bits; everything below is kept zero so OR-insertion works.
    always_comb begin
        len       = (i_total_length > InWidthL) ? FILL_W'(IN_WIDTH) : FILL_W'(i_total_length);
        word_mask = ~({IN_WIDTH{1'b1}} >> len);
        acc_new   = acc_q | ({i_word & word_mask, {OUT_WIDTH{1'b0}}} >> fill_q);
        fill_new  = fill_q + len;
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        fill_d    = fill_q;
        pending_d = pending_q;
        valid_d   = valid_q;
        data_d    = data_q;
        last_d    = last_q;
        count_d   = count_q;

        if (beat_release) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            StRun: begin
                if (accept) begin
                    if (fill_new >= OutWidthF) begin
                        valid_d = 1'b1;
                        data_d  = acc_new[ACC_W-1 -: OUT_WIDTH];
                        count_d = 8'(OUT_WIDTH);
                        last_d  = 1'b0;
                        acc_d   = acc_new << OUT_WIDTH;
                        fill_d  = fill_new - OutWidthF;
                        if (i_finish_final) begin
                            state_d   = StFlush;
                            last_d    = (fill_new == OutWidthF);
                            pending_d = (fill_new != OutWidthF);
                        end
                    end else begin
                        acc_d  = acc_new;
                        fill_d = fill_new;
                        // Final word with no full beat: the residual (possibly empty) is the last beat.
                        if (i_finish_final) begin
                            state_d   = StFlush;
                            valid_d   = 1'b1;
                            data_d    = pad_beat(acc_new[ACC_W-1 -: OUT_WIDTH], fill_new);
                            count_d   = 8'(fill_new);
                            last_d    = 1'b1;
                            pending_d = 1'b0;
                        end
                    end
                end
            end
            StFlush: begin
                if (beat_release && last_q) begin
                    state_d = StDone;
                end else if (pending_q && (!valid_q || i_out_ready)) begin
                    valid_d   = 1'b1;
                    data_d    = pad_beat(acc_q[ACC_W-1 -: OUT_WIDTH], fill_q);
                    count_d   = 8'(fill_q);
                    last_d    = 1'b1;
                    pending_d = 1'b0;
                end
            end
            StDone: begin
                acc_d   = '0;
                fill_d  = '0;
                state_d = StRun;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= StRun;
            acc_q     <= '0;
            fill_q    <= '0;
            pending_q <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            last_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            fill_q    <= fill_d;
            pending_q <= pending_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            last_q    <= last_d;
            count_q   <= count_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_data       = data_q;
    assign o_last       = last_q;
    assign o_bit_count  = count_q;
    assign o_fill_level = 8'(fill_q);

endmodule

// File: tb/tb_compressed_bit_packer.sv
// Self-checking bench for compressed_bit_packer; expected beats come from a bit-queue model.
module tb_compressed_bit_packer;

    localparam int IN_WIDTH  = 64;
    localparam int LEN_WIDTH = 7;
    localparam int OUT_WIDTH = 128;

`ifdef PACKER_PAD_ONES_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic                 i_clk = 1'b0;
    logic                 i_reset = 1'b1;
    logic                 i_valid = 1'b0;
    logic                 o_ready;
    logic [IN_WIDTH-1:0]  i_word = '0;
    logic [LEN_WIDTH-1:0] i_total_length = '0;
    logic                 i_finish_final = 1'b0;
    logic                 o_valid;
    logic                 i_out_ready = 1'b1;
    logic [OUT_WIDTH-1:0] o_data;
    logic                 o_last;
    logic [7:0]           o_bit_count;
    logic [7:0]           o_fill_level;

    compressed_bit_packer #(
        .IN_WIDTH (IN_WIDTH),
        .LEN_WIDTH(LEN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_word        (i_word),
        .i_total_length(i_total_length),
        .i_finish_final(i_finish_final),
        .o_valid       (o_valid),
        .i_out_ready   (i_out_ready),
        .o_data        (o_data),
        .o_last        (o_last),
        .o_bit_count   (o_bit_count),
        .o_fill_level  (o_fill_level)
    );

    always #5 i_clk = ~i_clk;

    int vectors     = 0;
    int miscompares = 0;
    bit stall_err   = 1'b0;
    int rdy_mode    = 0;  // 0: always ready, 1: random, 2: held low

    logic [IN_WIDTH-1:0]  w_q[$];
    int                   l_q[$];
    bit                   f_q[$];
    logic [OUT_WIDTH-1:0] e_data[$];
    int                   e_cnt[$];
    bit                   e_last[$];
    logic [OUT_WIDTH-1:0] got_data[$];
    int                   got_cnt[$];
    bit                   got_last[$];

    // Downstream ready, changed away from both sampling points.
    always @(posedge i_clk) begin
        #2;
        case (rdy_mode)
            0:       i_out_ready = 1'b1;
            1:       i_out_ready = ($urandom_range(0, 3) != 0);
            default: i_out_ready = 1'b0;
        endcase
    end

    always @(negedge i_clk) begin
        if (!i_reset && o_valid && i_out_ready) begin
            got_data.push_back(o_data);
            got_cnt.push_back(int'(o_bit_count));
            got_last.push_back(o_last);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // Reference: a plain bit stream, cut into 128-bit beats; finish flushes the remainder.
    function automatic void build_expected();
        bit                   bq[$];
        logic [OUT_WIDTH-1:0] d;
        bit                   made;
        int                   l;
        e_data.delete();
        e_cnt.delete();
        e_last.delete();
        foreach (w_q[i]) begin
            l = (l_q[i] > IN_WIDTH) ? IN_WIDTH : l_q[i];
            for (int b = 0; b < l; b++) bq.push_back(w_q[i][IN_WIDTH-1-b]);
            made = 1'b0;
            if (bq.size() >= OUT_WIDTH) begin
                for (int k = 0; k < OUT_WIDTH; k++) d[OUT_WIDTH-1-k] = bq.pop_front();
                e_data.push_back(d);
                e_cnt.push_back(OUT_WIDTH);
                e_last.push_back(1'b0);
                made = 1'b1;
            end
            if (f_q[i]) begin
                if (made && bq.size() == 0) begin
                    e_last[e_last.size()-1] = 1'b1;
                end else begin
                    d = PAD ? '1 : '0;
                    for (int k = 0; k < bq.size(); k++) d[OUT_WIDTH-1-k] = bq[k];
                    e_data.push_back(d);
                    e_cnt.push_back(bq.size());
                    e_last.push_back(1'b1);
                    bq.delete();
                end
            end
        end
    endfunction

    task automatic send_word(input logic [IN_WIDTH-1:0] w, input int len, input bit fin);
        int n;
        i_valid        = 1'b1;
        i_word         = w;
        i_total_length = LEN_WIDTH'(len);
        i_finish_final = fin;
        n = 0;
        @(negedge i_clk);
        while (!o_ready && n < 300) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_ready) stall_err = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid        = 1'b0;
        i_finish_final = 1'b0;
    endtask

    task automatic send_all();
        foreach (w_q[i]) send_word(w_q[i], l_q[i], f_q[i]);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (got_data.size() < e_data.size() && n < 2000) begin
            @(posedge i_clk);
            n++;
        end
        repeat (4) @(posedge i_clk);
        #1;
    endtask

    task automatic clear_got();
        got_data.delete();
        got_cnt.delete();
        got_last.delete();
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        vectors++;
        if (o_valid !== 1'b0 || o_last !== 1'b0 || o_data !== '0 || o_bit_count !== 8'd0 ||
            o_fill_level !== 8'd0 || o_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: valid=%b last=%b data=%h cnt=%0d fill=%0d ready=%b, required all 0",
                     o_valid, o_last, o_data, o_bit_count, o_fill_level, o_ready);
        end
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        @(negedge i_clk);
        vectors++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: ready=%b valid=%b, required ready=1 valid=0", o_ready, o_valid);
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_two_full_words();
        logic [OUT_WIDTH-1:0] exp;
        exp = {{8{8'hAA}}, {8{8'h55}}};
        w_q = '{{8{8'hAA}}, {8{8'h55}}};
        l_q = '{64, 64};
        f_q = '{1'b0, 1'b0};
        build_expected();
        clear_got();
        send_all();
        drain();
        vectors++;
        if (got_data.size() != 1) begin
            miscompares++;
            $display("FAIL two_words_count: %0d beats seen, 1 required", got_data.size());
        end
        if (got_data.size() >= 1) begin
            vectors++;
            if (got_data[0] !== exp || got_cnt[0] != 128 || got_last[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL two_words_beat: data=%h cnt=%0d last=%0b, required data=%h cnt=128 last=0",
                         got_data[0], got_cnt[0], got_last[0], exp);
            end
        end
        vectors++;
        if (o_fill_level !== 8'd0) begin
            miscompares++;
            $display("FAIL two_words_fill: fill=%0d, required 0", o_fill_level);
        end
    endtask

    task automatic test_forty_lengths();
        w_q = '{{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                {$urandom, $urandom}};
        l_q = '{40, 40, 40, 40};
        f_q = '{1'b0, 1'b0, 1'b0, 1'b1};
        build_expected();
        clear_got();
        for (int i = 0; i < 3; i++) send_word(w_q[i], l_q[i], f_q[i]);
        @(negedge i_clk);
        vectors++;
        if (o_fill_level !== 8'd120 || o_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL forty_fill: fill=%0d valid=%b, required fill=120 valid=0",
                     o_fill_level, o_valid);
        end
        @(posedge i_clk);
        #1;
        send_word(w_q[3], l_q[3], f_q[3]);
        drain();
        vectors++;
        if (got_data.size() != e_data.size() || e_cnt.size() != 2 || e_cnt[1] != 32) begin
            miscompares++;
            $display("FAIL forty_beats: %0d beats seen, %0d required (model count ok=%0b)",
                     got_data.size(), e_data.size(), e_cnt.size() == 2);
        end
        foreach (e_data[k]) begin
            if (k < got_data.size()) begin
                vectors++;
                if (got_data[k] !== e_data[k] || got_cnt[k] != e_cnt[k] || got_last[k] !== e_last[k]) begin
                    miscompares++;
                    $display("FAIL forty_beat%0d: data=%h cnt=%0d last=%0b, required data=%h cnt=%0d last=%0b",
                             k, got_data[k], got_cnt[k], got_last[k], e_data[k], e_cnt[k], e_last[k]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [IN_WIDTH-1:0] a, b, c;
        int n;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        c = {$urandom, $urandom};
        w_q = '{a, b, c, 64'h0};
        l_q = '{64, 64, 64, 0};
        f_q = '{1'b0, 1'b0, 1'b0, 1'b1};
        build_expected();
        rdy_mode = 2;
        repeat (2) @(posedge i_clk);
        #1;
        clear_got();
        send_word(a, 64, 1'b0);
        send_word(b, 64, 1'b0);
        i_valid        = 1'b1;
        i_word         = c;
        i_total_length = LEN_WIDTH'(64);
        repeat (5) begin
            @(negedge i_clk);
            vectors++;
            if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_data !== {a, b}) begin
                miscompares++;
                $display("FAIL stall_hold: ready=%b valid=%b data=%h, required ready=0 valid=1 data=%h",
                         o_ready, o_valid, o_data, {a, b});
            end
        end
        rdy_mode = 0;
        n = 0;
        @(negedge i_clk);
        while (!o_ready && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_ready) stall_err = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        send_word(64'h0, 0, 1'b1);
        drain();
        vectors++;
        if (got_data.size() != e_data.size()) begin
            miscompares++;
            $display("FAIL stall_beats: %0d beats seen, %0d required", got_data.size(), e_data.size());
        end
        foreach (e_data[k]) begin
            if (k < got_data.size()) begin
                vectors++;
                if (got_data[k] !== e_data[k] || got_cnt[k] != e_cnt[k] || got_last[k] !== e_last[k]) begin
                    miscompares++;
                    $display("FAIL stall_beat%0d: data=%h cnt=%0d last=%0b, required data=%h cnt=%0d last=%0b",
                             k, got_data[k], got_cnt[k], got_last[k], e_data[k], e_cnt[k], e_last[k]);
                end
            end
        end
    endtask

    task automatic test_empty_finish();
        logic [OUT_WIDTH-1:0] pad;
        pad = PAD ? '1 : '0;
        w_q = '{{$urandom, $urandom}};
        l_q = '{0};
        f_q = '{1'b1};
        build_expected();
        clear_got();
        send_all();
        drain();
        vectors++;
        if (got_data.size() != 1) begin
            miscompares++;
            $display("FAIL empty_count: %0d beats seen, 1 required", got_data.size());
        end
        if (got_data.size() >= 1) begin
            vectors++;
            if (got_data[0] !== pad || got_cnt[0] != 0 || got_last[0] !== 1'b1) begin
                miscompares++;
                $display("FAIL empty_beat: data=%h cnt=%0d last=%0b, required data=%h cnt=0 last=1",
                         got_data[0], got_cnt[0], got_last[0], pad);
            end
        end
    endtask

    task automatic test_saturate();
        logic [IN_WIDTH-1:0] w;
        w   = {$urandom, $urandom};
        w_q = '{w, {$urandom, $urandom}};
        l_q = '{100, 0};
        f_q = '{1'b0, 1'b1};
        build_expected();
        clear_got();
        send_all();
        drain();
        vectors++;
        if (got_data.size() != 1) begin
            miscompares++;
            $display("FAIL sat_count: %0d beats seen, 1 required", got_data.size());
        end
        if (got_data.size() >= 1) begin
            vectors++;
            if (got_cnt[0] != 64 || got_data[0][OUT_WIDTH-1 -: IN_WIDTH] !== w ||
                got_data[0] !== e_data[0] || got_last[0] !== 1'b1) begin
                miscompares++;
                $display("FAIL sat_beat: data=%h cnt=%0d last=%0b, required data=%h cnt=64 last=1",
                         got_data[0], got_cnt[0], got_last[0], e_data[0]);
            end
        end
    endtask

    task automatic test_reset_mid_block();
        rdy_mode = 2;
        repeat (2) @(posedge i_clk);
        #1;
        clear_got();
        send_word({$urandom, $urandom}, 35, 1'b0);
        send_word({$urandom, $urandom}, 35, 1'b1);
        @(negedge i_clk);
        vectors++;
        if (o_valid !== 1'b1 || o_fill_level !== 8'd70 || o_bit_count !== 8'd70) begin
            miscompares++;
            $display("FAIL midrst_pre: valid=%b fill=%0d cnt=%0d, required valid=1 fill=70 cnt=70",
                     o_valid, o_fill_level, o_bit_count);
        end
        @(posedge i_clk);
        #1;
        i_reset  = 1'b1;
        rdy_mode = 0;
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        @(negedge i_clk);
        vectors++;
        if (o_valid !== 1'b0 || o_fill_level !== 8'd0 || o_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_post: valid=%b fill=%0d ready=%b, required valid=0 fill=0 ready=1",
                     o_valid, o_fill_level, o_ready);
        end
        @(posedge i_clk);
        #1;
        clear_got();
        w_q = '{{$urandom, $urandom}, {$urandom, $urandom}};
        l_q = '{64, 64};
        f_q = '{1'b0, 1'b1};
        build_expected();
        send_all();
        drain();
        vectors++;
        if (got_data.size() != 1) begin
            miscompares++;
            $display("FAIL midrst_count: %0d beats seen, 1 required", got_data.size());
        end
        if (got_data.size() >= 1) begin
            vectors++;
            if (got_data[0] !== e_data[0] || got_cnt[0] != 128 || got_last[0] !== 1'b1) begin
                miscompares++;
                $display("FAIL midrst_beat: data=%h cnt=%0d last=%0b, required data=%h cnt=128 last=1",
                         got_data[0], got_cnt[0], got_last[0], e_data[0]);
            end
        end
    endtask

    task automatic test_random_stream();
        w_q.delete();
        l_q.delete();
        f_q.delete();
        for (int i = 0; i < 80; i++) begin
            w_q.push_back({$urandom, $urandom});
            l_q.push_back($urandom_range(0, 100));
            f_q.push_back(($urandom_range(0, 9) == 0) || (i == 79));
        end
        build_expected();
        rdy_mode = 1;
        clear_got();
        send_all();
        drain();
        rdy_mode = 0;
        repeat (3) @(posedge i_clk);
        #1;
        vectors++;
        if (got_data.size() != e_data.size() || stall_err) begin
            miscompares++;
            $display("FAIL rand_beats: %0d beats seen, %0d required, stall=%0b (required 0)",
                     got_data.size(), e_data.size(), stall_err);
        end
        foreach (e_data[k]) begin
            if (k < got_data.size()) begin
                vectors++;
                if (got_data[k] !== e_data[k] || got_cnt[k] != e_cnt[k] || got_last[k] !== e_last[k]) begin
                    miscompares++;
                    $display("FAIL rand_beat%0d: data=%h cnt=%0d last=%0b, required data=%h cnt=%0d last=%0b",
                             k, got_data[k], got_cnt[k], got_last[k], e_data[k], e_cnt[k], e_last[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_two_full_words();
        test_forty_lengths();
        test_backpressure();
        test_empty_finish();
        test_saturate();
        test_reset_mid_block();
        test_random_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
